alu_serial: RTL

- Parametrised bit-serial ALU; successor to the fixed 16-bit alu16.
- Processes operands LSB-first, one bit per clk, under a start/busy/done handshake.
- Driven from the ring-oscillator clock domain; a single clock in total.
- Adds a synchronous reset, a done/busy handshake, a wider opcode set and a configurable width over alu16.

---
 rtl/alu_serial_pkg.sv | 26 ++
 rtl/alu_serial_bit.sv | 41 ++++
 rtl/alu_serial.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_serial_pkg.sv
// Opcodes, FSM state type and carry-preset helper shared by the alu_serial files.
package alu_serial_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD   = 3'b000;
   localparam op_t OP_SUB   = 3'b001;
   localparam op_t OP_AND   = 3'b010;
   localparam op_t OP_OR    = 3'b011;
   localparam op_t OP_XOR   = 3'b100;
   localparam op_t OP_PASSA = 3'b101;
   localparam op_t OP_INC   = 3'b110;
   localparam op_t OP_DEC   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // SUB (two's complement of B) and INC both need an initial carry of one.
   function automatic logic carry_preset(input op_t op);
      return (op == OP_SUB) || (op == OP_INC);
   endfunction

endpackage

// File: rtl/alu_serial_bit.sv
// Combinational one-bit slice of the serial ALU: result bit and carry-out.
module alu_serial_bit
   import alu_serial_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   input  op_t  op_i,
   output logic r_o,
   output logic cout_o
);

   logic b_eff;
   logic arith;

   always_comb begin
      b_eff  = b_i;
      arith  = 1'b1;
      r_o    = 1'b0;
      cout_o = 1'b0;
      case (op_i)
         OP_ADD:  b_eff = b_i;
         OP_SUB:  b_eff = ~b_i;
         OP_INC:  b_eff = 1'b0;
         OP_DEC:  b_eff = 1'b1;
         default: arith = 1'b0;
      endcase
      if (arith) begin
         r_o    = a_i ^ b_eff ^ cin_i;
         cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
      end else begin
         case (op_i)
            OP_AND:  r_o = a_i & b_i;
            OP_OR:   r_o = a_i | b_i;
            OP_XOR:  r_o = a_i ^ b_i;
            default: r_o = a_i;
         endcase
      end
   end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial ALU, LSB-first, start/busy/done handshake.
// Optional `ALU_SERIAL_FLAGS_EN adds flags = {zero, neg, ovf}.
module alu_serial
   import alu_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             on,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic [2:0]       op,
   output logic [WIDTH:0]   out,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done
`ifdef ALU_SERIAL_FLAGS_EN
   ,
   output logic [2:0]       flags
`endif
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   op_t              op_q, op_d;
   logic             carry_q, carry_d;
   logic [WIDTH:0]   out_q, out_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             done_q, done_d;
   logic             bit_r, bit_c;

   alu_serial_bit u_bit (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .cin_i  (carry_q),
      .op_i   (op_q),
      .r_o    (bit_r),
      .cout_o (bit_c)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      op_d    = op_q;
      carry_d = carry_q;
      out_d   = out_q;
      count_d = count_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (on) begin
               a_d     = ina;
               b_d     = inb;
               op_d    = op;
               carry_d = carry_preset(op);
               res_d   = '0;
               out_d   = '0;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Result enters at the MSB so after WIDTH shifts bit 0 sits at index 0.
            res_d   = {bit_r, res_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = bit_c;
            if (count_q == LAST) begin
               count_d = '0;
               state_d = DONE;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         DONE: begin
            out_d   = {carry_q, res_q};
            done_d  = 1'b1;
            count_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= OP_ADD;
         carry_q <= 1'b0;
         out_q   <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         out_q   <= out_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign out   = out_q;
   assign count = count_q;
   assign busy  = (state_q == RUN);
   assign done  = done_q;

`ifdef ALU_SERIAL_FLAGS_EN
   logic       zero_q, zero_d;
   logic       ovf_q, ovf_d;
   logic [2:0] flags_q, flags_d;

   always_comb begin
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      flags_d = flags_q;
      case (state_q)
         IDLE: begin
            if (on) begin
               zero_d  = 1'b1;
               ovf_d   = 1'b0;
               flags_d = '0;
            end
         end
         RUN: begin
            zero_d = zero_q & ~bit_r;
            // Signed overflow: carry into the MSB differs from carry out of it.
            if (count_q == LAST) ovf_d = carry_q ^ bit_c;
         end
         DONE:    flags_d = {zero_q, res_q[WIDTH-1], ovf_q};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         flags_q <= '0;
      end else begin
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;
`endif

endmodule
